// File: rtl/pixel_sram_writer_if.sv
// Pixel/SRAM bus bundle for pixel_sram_writer.
//   vsync, pix_valid, pix_data : committed pixel stream from the camera side
//   sram_addr .. sram_bheb     : async SRAM write port (controls active low)
//   busy, frame_done, ovf      : writer status
// The writer connects through the slave modport; the pixel source and SRAM
// side (or a bench) use the master modport.
interface pixel_sram_writer_if #(
  parameter int ADDR_W = 16
);
  logic              vsync;
  logic              pix_valid;
  logic [11:0]       pix_data;
  logic [ADDR_W-1:0] sram_addr;
  logic [15:0]       sram_dq;
  logic              sram_ceb;
  logic              sram_web;
  logic              sram_oeb;
  logic              sram_bleb;
  logic              sram_bheb;
  logic              busy;
  logic              frame_done;
  logic              ovf;

  modport master (
    output vsync, pix_valid, pix_data,
    input  sram_addr, sram_dq, sram_ceb, sram_web, sram_oeb, sram_bleb, sram_bheb,
    input  busy, frame_done, ovf
  );

  modport slave (
    input  vsync, pix_valid, pix_data,
    output sram_addr, sram_dq, sram_ceb, sram_web, sram_oeb, sram_bleb, sram_bheb,
    output busy, frame_done, ovf
  );
endinterface

// File: rtl/pixel_sram_writer.sv
// pixel_sram_writer
// Buffers committed RGB444 pixels in a small FIFO and writes each one into an
// async 16-bit SRAM at a linearly incrementing frame address, using a fixed
// 3-cycle write (SETUP, STROBE, RECOVER). Flags frame completion and overflow.
// Ports:
//   pclk : pixel clock, all logic on the rising edge
//   resb : asynchronous active-low reset
//   bus  : pixel input, SRAM write port and status (pixel_sram_writer_if.slave)
module pixel_sram_writer #(
  parameter int ADDR_W       = 16,
  parameter int FIFO_DEPTH   = 4,
  parameter int FRAME_PIXELS = 19200
) (
  input  logic                 pclk,
  input  logic                 resb,
  pixel_sram_writer_if.slave   bus
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_COUNT    = CNT_W'(FIFO_DEPTH);
  localparam logic [ADDR_W:0]  FRAME_END_INC = (ADDR_W + 1)'(FRAME_PIXELS);

  // The address must never wrap inside a frame.
  if (FRAME_PIXELS > (2 ** ADDR_W)) begin : g_bad_frame
    $error("FRAME_PIXELS exceeds the SRAM address space");
  end
  if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of two and at least 2");
  end

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, RECOVER} state_t;

  state_t            state_reg;
  logic              vsync_prev_reg;
  logic              abort_reg;      // vsync edge seen during SETUP/STROBE
  logic [ADDR_W-1:0] addr_reg;
  logic [11:0]       fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_reg;
  logic [PTR_W-1:0]  rd_ptr_reg;
  logic [CNT_W-1:0]  count_reg;
  logic [ADDR_W-1:0] sram_addr_reg;
  logic [15:0]       sram_dq_reg;
  logic              ceb_reg;
  logic              web_reg;
  logic              byte_en_b_reg;  // shared by both byte lanes
  logic              frame_done_reg;
  logic              ovf_reg;

  logic              vsync_edge;
  logic              fifo_empty;
  logic              fifo_full;
  logic              accept_ok;
  logic              push;
  logic              drop_full;
  logic [ADDR_W:0]   addr_inc;
  logic              write_done;
  logic              frame_end;
  logic              can_pop;
  logic              pop;
  logic [11:0]       fifo_head;

  assign vsync_edge = bus.vsync & ~vsync_prev_reg;
  assign fifo_empty = (count_reg == '0);
  assign fifo_full  = (count_reg == FULL_COUNT);
  // A pixel coinciding with a frame start or arriving after frame completion
  // is discarded without counting as an overflow.
  assign accept_ok  = bus.pix_valid & ~frame_done_reg & ~vsync_edge;
  assign push       = accept_ok & ~fifo_full;
  assign drop_full  = accept_ok & fifo_full;
  // One extra bit so the frame-end compare works even when FRAME_PIXELS fills
  // the whole address space.
  assign addr_inc   = {1'b0, addr_reg} + 1'b1;
  // A write only counts when it finished without a frame restart.
  assign write_done = (state_reg == RECOVER) & ~abort_reg & ~vsync_edge;
  assign frame_end  = write_done & (addr_inc == FRAME_END_INC);
  assign can_pop    = ~fifo_empty & ~frame_done_reg & ~vsync_edge;
  assign pop        = ((state_reg == IDLE) & can_pop) | (write_done & ~frame_end & can_pop);
  assign fifo_head  = fifo_mem[rd_ptr_reg];

  always_ff @(posedge pclk) begin
    if (push) begin
      fifo_mem[wr_ptr_reg] <= bus.pix_data;
    end
  end

  always_ff @(posedge pclk or negedge resb) begin
    if (!resb) begin
      state_reg      <= IDLE;
      vsync_prev_reg <= 1'b0;
      abort_reg      <= 1'b0;
      addr_reg       <= '0;
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      count_reg      <= '0;
      sram_addr_reg  <= '0;
      sram_dq_reg    <= '0;
      ceb_reg        <= 1'b1;
      web_reg        <= 1'b1;
      byte_en_b_reg  <= 1'b1;
      frame_done_reg <= 1'b0;
      ovf_reg        <= 1'b0;
    end else begin
      vsync_prev_reg <= bus.vsync;

      // Leftover pixels are discarded both at a frame restart and once the
      // frame is full, so busy falls back to 0 after the last write.
      if (vsync_edge || frame_end) begin
        wr_ptr_reg <= '0;
        rd_ptr_reg <= '0;
        count_reg  <= '0;
      end else begin
        if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
        if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
        count_reg <= count_reg + CNT_W'(push) - CNT_W'(pop);
      end

      if (vsync_edge)     ovf_reg <= 1'b0;
      else if (drop_full) ovf_reg <= 1'b1;

      if (vsync_edge)     frame_done_reg <= 1'b0;
      else if (frame_end) frame_done_reg <= 1'b1;

      if (vsync_edge)      addr_reg <= '0;
      else if (write_done) addr_reg <= addr_inc[ADDR_W-1:0];

      case (state_reg)
        IDLE: begin
          if (pop) begin
            state_reg     <= SETUP;
            sram_addr_reg <= addr_reg;
            sram_dq_reg   <= {4'h0, fifo_head};
            ceb_reg       <= 1'b0;
            byte_en_b_reg <= 1'b0;
            web_reg       <= 1'b1;
          end
        end
        SETUP: begin
          state_reg <= STROBE;
          web_reg   <= 1'b0;
          if (vsync_edge) abort_reg <= 1'b1;
        end
        STROBE: begin
          // The strobe always runs its full cycle, even on a frame restart.
          state_reg <= RECOVER;
          web_reg   <= 1'b1;
          if (vsync_edge) abort_reg <= 1'b1;
        end
        RECOVER: begin
          abort_reg <= 1'b0;
          if (pop) begin
            state_reg     <= SETUP;
            sram_addr_reg <= addr_inc[ADDR_W-1:0];
            sram_dq_reg   <= {4'h0, fifo_head};
          end else begin
            state_reg     <= IDLE;
            ceb_reg       <= 1'b1;
            byte_en_b_reg <= 1'b1;
          end
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign bus.sram_addr  = sram_addr_reg;
  assign bus.sram_dq    = sram_dq_reg;
  assign bus.sram_ceb   = ceb_reg;
  assign bus.sram_web   = web_reg;
  assign bus.sram_oeb   = 1'b1;
  assign bus.sram_bleb  = byte_en_b_reg;
  assign bus.sram_bheb  = byte_en_b_reg;
  assign bus.busy       = (state_reg != IDLE) | ~fifo_empty;
  assign bus.frame_done = frame_done_reg;
  assign bus.ovf        = ovf_reg;

endmodule
